// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes and default widths shared by the write-response path.
package axi_pkg;
   typedef logic [1:0] resp_t;
   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;
   localparam int ID_W_DEF = 4;
endpackage

// File: rtl/b_resp_fifo.sv
// b_resp_fifo: synchronous FIFO with combinational head read; a push into a full queue is
// accepted when a pop happens in the same cycle.
module b_resp_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == CNT_W'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   // full/empty come from the count, so pointers are free to wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/b_resp_gen.sv
// b_resp_gen: turns decoder completion pulses into queued AXI B-channel responses
// and drives the BVALID/BREADY handshake.
module b_resp_gen
   import axi_pkg::*;
#(
   parameter int ID_W  = ID_W_DEF,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             done_legal,
   input  logic             done_err,
   input  logic             done_illegal,
   input  logic [ID_W-1:0]  done_id,
   input  logic             bready,
   output logic             bvalid,
   output logic [ID_W-1:0]  bid,
   output logic [1:0]       bresp,
   output logic             resp_full,
   output logic [CNT_W-1:0] resp_count,
   output logic             resp_ovf
);
   resp_t           code;
   logic            done_any, pop, empty;
   logic [ID_W+1:0] head;
   assign done_any = done_legal | done_err | done_illegal;
   assign pop      = bvalid & bready;
   always_comb
      code = done_illegal ? RESP_DECERR : done_err ? RESP_SLVERR : RESP_OKAY;
   b_resp_fifo #(.W(ID_W + 2), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (done_any),
      .pop   (pop),
      .din   ({done_id, code}),
      .dout  (head),
      .full  (resp_full),
      .empty (empty),
      .count (resp_count)
   );
   // outputs read zero while idle so stale storage never leaks onto the bus
   assign bvalid = ~empty;
   assign bid    = bvalid ? head[ID_W+1:2] : '0;
   assign bresp  = bvalid ? head[1:0] : '0;
   always_ff @(posedge clk) begin
      if (reset) resp_ovf <= 1'b0;
      else if (done_any & resp_full & ~pop) resp_ovf <= 1'b1;
   end
endmodule
